tls_junction_ctrl: RTL

- Sequences a two-road junction (road A, road B) as one six-phase cycle.
- Phase order: A green, A yellow, all-red clearance, B green, B yellow, all-red clearance.
- Phase durations are programmable. Pedestrian requests shorten green; an emergency input forces all-red.
- Sits above the per-road light outputs as the single source of phase timing, so both roads can never show non-red at the same time.

---
 rtl/tls_junction_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tls_junction_ctrl.sv
// Purpose: six-phase two-road junction sequencer (A_G,A_Y,AR1,B_G,B_Y,AR2) with programmable durations, ped shortening, emergency all-red.
// Latency: lamps/phase are a registered-state decode, visible right after the edge that changes state; durations apply from the edge after set.
// Backpressure: no handshake; hold freezes state and counter (ped requests still latch), emerg overrides hold, set overrides everything.
//
// Ports:
//   clk, reset (async active-low)  | set + gin/yin/arin : load durations and restart at AR2
//   hold, ped_req, emerg           | a_g/a_y/a_r, b_g/b_y/b_r : lamps, one per road
//   phase (0..6, 6 = EMERG)        | ped_pend : pedestrian request latched
module tls_junction_ctrl #(
  parameter int CW      = 4,
  parameter int DEF_G   = 8,
  parameter int DEF_Y   = 3,
  parameter int DEF_AR  = 1,
  parameter int PED_MIN = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic [CW-1:0] gin,
  input  logic [CW-1:0] yin,
  input  logic [CW-1:0] arin,
  input  logic          hold,
  input  logic          ped_req,
  input  logic          emerg,
  output logic          a_g,
  output logic          a_y,
  output logic          a_r,
  output logic          b_g,
  output logic          b_y,
  output logic          b_r,
  output logic [2:0]    phase,
  output logic          ped_pend
);

  typedef enum logic [2:0] {
    S_AG  = 3'd0,
    S_AY  = 3'd1,
    S_AR1 = 3'd2,
    S_BG  = 3'd3,
    S_BY  = 3'd4,
    S_AR2 = 3'd5,
    S_EM  = 3'd6
  } state_t;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] PED_MIN_W = CW'(PED_MIN);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] g_q, g_d, y_q, y_d, ar_q, ar_d;
  logic          ped_q, ped_d;

  logic [CW-1:0] dur_raw, dur_eff, ped_lim;
  logic          is_last, ped_hit, clr;

  // Duration of the current phase; a programmed 0 behaves as 1 so every
  // phase occupies at least one cycle and the counter compare stays valid.
  always_comb begin
    dur_raw = ar_q;
    case (state_q)
      S_AG, S_BG: dur_raw = g_q;
      S_AY, S_BY: dur_raw = y_q;
      default:    dur_raw = ar_q;
    endcase
    dur_eff = (dur_raw == '0) ? ONE : dur_raw;
    ped_lim = (dur_eff < PED_MIN_W) ? dur_eff : PED_MIN_W;
    is_last = (cnt_q == dur_eff - ONE);
    // >= rather than == so a request latched late still ends green next edge
    ped_hit = ped_q && (cnt_q >= ped_lim - ONE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    y_d     = y_q;
    ar_d    = ar_q;
    clr     = 1'b0;
    if (set) begin
      g_d     = gin;
      y_d     = yin;
      ar_d    = arin;
      state_d = S_AR2;
      cnt_d   = '0;
    end else if (emerg) begin
      case (state_q)
        S_AG: begin state_d = S_AY; cnt_d = '0; clr = 1'b1; end
        S_BG: begin state_d = S_BY; cnt_d = '0; clr = 1'b1; end
        S_AY, S_BY: begin
          if (is_last) begin
            state_d = S_EM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin state_d = S_EM; cnt_d = '0; end
      endcase
    end else if (!hold) begin
      case (state_q)
        S_EM: begin state_d = S_AR2; cnt_d = '0; end
        S_AG, S_BG: begin
          if (is_last || ped_hit) begin
            state_d = (state_q == S_AG) ? S_AY : S_BY;
            cnt_d   = '0;
            clr     = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          if (is_last) begin
            cnt_d = '0;
            case (state_q)
              S_AY:    state_d = S_AR1;
              S_AR1:   state_d = S_BG;
              S_BY:    state_d = S_AR2;
              default: state_d = S_AG;
            endcase
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      endcase
    end
    // A request on the clearing edge survives and serves the next green.
    ped_d = set ? 1'b0 : (ped_req | (ped_q & ~clr));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_AR2;
      cnt_q   <= '0;
      g_q     <= CW'(DEF_G);
      y_q     <= CW'(DEF_Y);
      ar_q    <= CW'(DEF_AR);
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      y_q     <= y_d;
      ar_q    <= ar_d;
      ped_q   <= ped_d;
    end
  end

  always_comb begin
    a_g = 1'b0; a_y = 1'b0; a_r = 1'b1;
    b_g = 1'b0; b_y = 1'b0; b_r = 1'b1;
    case (state_q)
      S_AG:    begin a_g = 1'b1; a_r = 1'b0; end
      S_AY:    begin a_y = 1'b1; a_r = 1'b0; end
      S_BG:    begin b_g = 1'b1; b_r = 1'b0; end
      S_BY:    begin b_y = 1'b1; b_r = 1'b0; end
      default: ;
    endcase
    phase    = state_q;
    ped_pend = ped_q;
  end

endmodule
